// File: rtl/decay_pkg.sv
// Shared definitions for the membrane-potential decay engine:
// decay-mode encodings and the sweep FSM state type.
package decay_pkg;

    localparam logic [2:0] NONE   = 3'b000;
    localparam logic [2:0] LIF2   = 3'b001;
    localparam logic [2:0] LIF4   = 3'b010;
    localparam logic [2:0] LIF8   = 3'b011;
    localparam logic [2:0] LIF16  = 3'b100;
    localparam logic [2:0] LINEAR = 3'b101;
    localparam logic [2:0] IZHI   = 3'b110;
    localparam logic [2:0] REST   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SWEEP = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/decay_alu.sv
// Combinational decay rule for one neuron: maps the stored potential and its
// mode to the decayed potential. No rule can overflow WIDTH bits.
module decay_alu
    import decay_pkg::*;
#(
    parameter int                       WIDTH  = 32,
    parameter logic [WIDTH-1:0]         LEAK   = 100,
    parameter logic signed [WIDTH-1:0]  V_REST = '0
) (
    input  logic signed [WIDTH-1:0] v,
    input  logic [2:0]              mode,
    output logic signed [WIDTH-1:0] v_next
);

    localparam logic signed [WIDTH-1:0] LEAK_S = signed'(LEAK);

    always_comb begin
        v_next = v;
        case (mode)
            NONE:   v_next = v;
            LIF2:   v_next = v - (v >>> 1);
            LIF4:   v_next = v - (v >>> 2);
            LIF8:   v_next = v - (v >>> 3);
            LIF16:  v_next = v - (v >>> 4);
            // Values inside the +/-LEAK band snap to zero rather than crossing it
            LINEAR: begin
                if (v > LEAK_S)
                    v_next = v - LEAK_S;
                else if (v < -LEAK_S)
                    v_next = v + LEAK_S;
                else
                    v_next = '0;
            end
            IZHI:   v_next = v - (v >>> 3) - (v >>> 5);
            REST:   v_next = V_REST;
            default: v_next = v;
        endcase
    end

endmodule

// File: rtl/potential_decay_array.sv
// Multi-neuron decay engine: holds per-neuron potentials and modes, sweeps one
// neuron per cycle on time_step and streams each updated potential downstream.
//
// state    | meaning
// ST_IDLE  | waiting; loads accepted, time_step starts a sweep at idx 0
// ST_SWEEP | neuron idx updated this cycle; leaves after idx == N_NEURONS-1
// ST_DONE  | two cycles: first raises done, second returns to IDLE
module potential_decay_array
    import decay_pkg::*;
#(
    parameter int                       WIDTH     = 32,
    parameter int                       N_NEURONS = 16,
    parameter int                       AW        = $clog2(N_NEURONS),
    parameter logic [WIDTH-1:0]         LEAK      = 100,
    parameter logic signed [WIDTH-1:0]  V_REST    = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             time_step,
    input  logic             load,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] new_potential,
    input  logic [2:0]       wr_mode,
    output logic             load_ready,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_potential,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    output logic [AW-1:0]    out_idx,
    output logic [WIDTH-1:0] out_potential,
    output logic             overrun
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N_NEURONS - 1);

    logic signed [WIDTH-1:0] pot    [N_NEURONS];
    logic [2:0]              mode_r [N_NEURONS];
    state_t                  state;
    logic [AW-1:0]           idx;
    logic signed [WIDTH-1:0] alu_v;

    decay_alu #(
        .WIDTH  (WIDTH),
        .LEAK   (LEAK),
        .V_REST (V_REST)
    ) u_alu (
        .v      (pot[idx]),
        .mode   (mode_r[idx]),
        .v_next (alu_v)
    );

    assign load_ready = ~busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                pot[i]    <= '0;
                mode_r[i] <= NONE;
            end
            state         <= ST_IDLE;
            idx           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            out_valid     <= 1'b0;
            out_idx       <= '0;
            out_potential <= '0;
            overrun       <= 1'b0;
            rd_potential  <= '0;
        end else begin
            rd_potential <= pot[rd_addr];
            out_valid    <= 1'b0;
            done         <= 1'b0;
            if (time_step && busy)
                overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    // A same-cycle load lands before the sweep reads neuron 0
                    if (load) begin
                        pot[wr_addr]    <= signed'(new_potential);
                        mode_r[wr_addr] <= wr_mode;
                    end
                    if (time_step) begin
                        state <= ST_SWEEP;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    pot[idx]      <= alu_v;
                    out_valid     <= 1'b1;
                    out_idx       <= idx;
                    out_potential <= alu_v;
                    if (idx == LAST_IDX)
                        state <= ST_DONE;
                    else
                        idx <= idx + 1'b1;
                end
                ST_DONE: begin
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
